control_sequencer: RTL

Microcoded control unit for the eight-bit bus computer. Runs a fixed five-step fetch/execute cycle and decodes the 4-bit opcode from the instruction register. Drives every load, enable and ALU control line of the shared 8-bit bus datapath: PC, MAR, RAM, IR, A, B, ALU and OUT. Holds the carry and zero flags and stops the machine on HLT.

---
 rtl/control_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Microcoded five-step fetch/execute sequencer for the 8-bit bus computer.
// Optional flags register and conditional jumps are enabled by defining COND_JUMP_EN.
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       carry_in,
  input  logic       zero_in,
  output logic       hlt,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       ii,
  output logic       io,
  output logic       ai,
  output logic       ao,
  output logic       bi,
  output logic       eo,
  output logic       su,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       j,
  output logic       fi,
  output logic [2:0] step
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic ii;
    logic io;
    logic ai;
    logic ao;
    logic bi;
    logic eo;
    logic su;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } ctrl_t;

  logic [2:0] step_q;
  logic       halted;
  logic       carry_flag;
  logic       zero_flag;
  ctrl_t      dec;

  // Sequencer: step advances every clock until HLT freezes it at T2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= T0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (step_q == T2 && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else if (step_q >= T4) begin
        step_q <= T0;
      end else begin
        step_q <= step_q + 3'd1;
      end
    end
  end

`ifdef COND_JUMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (fi) begin
      carry_flag <= carry_in;
      zero_flag  <= zero_in;
    end
  end
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = carry_in ^ zero_in;
  assign carry_flag = 1'b0;
  assign zero_flag  = 1'b0;
`endif

  // Microcode decode from registered step and the IR opcode.
  always_comb begin
    dec = '0;
    case (step_q)
      T0: begin
        dec.co = 1'b1;
        dec.mi = 1'b1;
      end
      T1: begin
        dec.ro = 1'b1;
        dec.ii = 1'b1;
        dec.ce = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            dec.io = 1'b1;
            dec.mi = 1'b1;
          end
          OP_LDI: begin
            dec.io = 1'b1;
            dec.ai = 1'b1;
          end
          OP_JMP: begin
            dec.io = 1'b1;
            dec.j  = 1'b1;
          end
`ifdef COND_JUMP_EN
          OP_JC: begin
            dec.io = carry_flag;
            dec.j  = carry_flag;
          end
          OP_JZ: begin
            dec.io = zero_flag;
            dec.j  = zero_flag;
          end
`endif
          OP_OUT: begin
            dec.ao = 1'b1;
            dec.oi = 1'b1;
          end
          OP_HLT: dec.hlt = 1'b1;
          default: dec = '0;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            dec.ro = 1'b1;
            dec.ai = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            dec.ro = 1'b1;
            dec.bi = 1'b1;
          end
          OP_STA: begin
            dec.ao = 1'b1;
            dec.ri = 1'b1;
          end
          default: dec = '0;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          dec.eo = 1'b1;
          dec.ai = 1'b1;
          dec.su = (opcode == OP_SUB);
`ifdef COND_JUMP_EN
          dec.fi = 1'b1;
`endif
        end
      end
      default: dec = '0;
    endcase
  end

  // Reset forces everything low at once; halt leaves only hlt active.
  logic run_ok;
  assign run_ok = rst_n & ~halted;

  assign hlt  = rst_n & (halted | dec.hlt);
  assign mi   = run_ok & dec.mi;
  assign ri   = run_ok & dec.ri;
  assign ro   = run_ok & dec.ro;
  assign ii   = run_ok & dec.ii;
  assign io   = run_ok & dec.io;
  assign ai   = run_ok & dec.ai;
  assign ao   = run_ok & dec.ao;
  assign bi   = run_ok & dec.bi;
  assign eo   = run_ok & dec.eo;
  assign su   = run_ok & dec.su;
  assign oi   = run_ok & dec.oi;
  assign ce   = run_ok & dec.ce;
  assign co   = run_ok & dec.co;
  assign j    = run_ok & dec.j;
  assign fi   = run_ok & dec.fi;
  assign step = step_q;

endmodule
